oci_trace_capture: RTL and testbench

Parametrised capture buffer for the Nios II on-chip-instrumentation debug compressed trace (DCT) stream. It replaces the empty simulation-only OCI test-bench stub with a synthesizable block that:
- packs each non-empty DCT beat into a FIFO entry;
- drains entries over a valid/ready port;
- counts beats dropped on overflow;
- runs an end-of-test drain handshake.

It sits beside the CPU's OCI trace unit in each core of the multicore system.

---
 rtl/oci_trace_capture.sv | 151 +++++++++++++++
 tb/tb_oci_trace_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oci_trace_capture.sv
// oci_trace_capture: capture buffer for the Nios II OCI compressed trace (DCT)
// stream. Each non-empty beat is packed into a FIFO entry {ts, count, buffer}
// and drained over a valid/ready port. Dropped beats are counted, and an
// end-of-test handshake drains the FIFO and then raises test_has_ended.
// Optional feature: define OCI_TRACE_TIMESTAMP_EN to prepend a TS_W-bit
// free-running cycle counter to each entry.
module oci_trace_capture #(
  parameter int SLOTS  = 5,
  parameter int SLOT_W = 6,
  parameter int DEPTH  = 16,
  parameter int OVF_W  = 16,
  parameter int TS_W   = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [SLOTS*SLOT_W-1:0]     dct_buffer,
  input  logic [3:0]                  dct_count,
  input  logic                        test_ending,
`ifdef OCI_TRACE_TIMESTAMP_EN
  output logic [TS_W+4+SLOTS*SLOT_W-1:0] trc_data,
`else
  output logic [4+SLOTS*SLOT_W-1:0]   trc_data,
`endif
  output logic                        trc_valid,
  input  logic                        trc_ready,
  output logic [OVF_W-1:0]            ovf_count,
  output logic                        count_err,
  output logic                        test_has_ended,
  output logic [$clog2(DEPTH):0]      fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int E_W = $bits(trc_data);
  localparam logic [3:0] SLOTS_C = 4'(SLOTS);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [OVF_W-1:0] OVF_ONE = {{(OVF_W-1){1'b0}}, 1'b1};

  // Reject parameter sets the entry packing and pointer scheme cannot handle.
  if (SLOTS < 1 || SLOTS > 15 || SLOT_W < 1 || DEPTH < 2 || DEPTH > 256 ||
      (DEPTH & (DEPTH - 1)) != 0 || OVF_W < 1 || TS_W < 1) begin : g_bad_param
    $error("oci_trace_capture: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENDED = 2'd2
  } state_e;

  // Saturating increment: the drop counter sticks at all-ones.
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : (v + OVF_ONE);
  endfunction

  // Clamp an out-of-range slot count to the number of physical slots.
  function automatic logic [3:0] clamp_count(input logic [3:0] c);
    return (c > SLOTS_C) ? SLOTS_C : c;
  endfunction

  state_e            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic              err_q, err_d;
  logic [E_W-1:0]    mem_q [DEPTH];
  logic [E_W-1:0]    entry_d;

  logic              empty, full, beat, pop, wr_en, drop;
  logic [AW:0]       fill;

`ifdef OCI_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_q;
  localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};

  // Free-running cycle counter stamped into each captured entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + TS_ONE;
  end

  assign entry_d = {ts_q, clamp_count(dct_count), dct_buffer};
`else
  assign entry_d = {clamp_count(dct_count), dct_buffer};
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign fill  = wr_ptr_q - rd_ptr_q;

  // Head of queue comes straight from storage flops; zero when nothing valid.
  assign trc_valid      = !empty;
  assign trc_data       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign fill_level     = fill;
  assign ovf_count      = ovf_q;
  assign count_err      = err_q;
  assign test_has_ended = (state_q == ST_ENDED);

  // Capture/drop decisions, status next-state and the end-of-test FSM.
  always_comb begin
    beat     = (dct_count != 4'd0) && (state_q == ST_RUN);
    pop      = !empty && trc_ready;
    wr_en    = beat && (!full || pop);
    drop     = beat && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    state_d  = state_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (drop)  ovf_d = sat_inc(ovf_q);
    if (beat && (dct_count > SLOTS_C)) err_d = 1'b1;
    case (state_q)
      ST_RUN: begin
        // A beat in the same cycle is still captured above.
        if (test_ending) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // No writes in DRAIN: the FIFO is empty after this edge when it is
        // already empty or the last entry is popping now.
        if (empty || ((fill == PTR_ONE) && pop)) state_d = ST_ENDED;
      end
      ST_ENDED: state_d = ST_ENDED;
      default:  state_d = ST_RUN;
    endcase
  end

  // Control state: pointers, status counters and FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Entry storage; data only, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= entry_d;
  end

endmodule

// File: tb/tb_oci_trace_capture.sv
// Directed testbench for oci_trace_capture (default parameters).
module tb_oci_trace_capture;

  localparam int SLOTS = 5;
  localparam int SLOT_W = 6;
  localparam int DEPTH = 16;
  localparam int OVF_W = 16;
  localparam int TS_W = 32;
  localparam int BW = SLOTS * SLOT_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [BW-1:0]     dct_buffer;
  logic [3:0]        dct_count;
  logic              test_ending;
`ifdef OCI_TRACE_TIMESTAMP_EN
  logic [TS_W+4+BW-1:0] trc_data;
`else
  logic [4+BW-1:0]   trc_data;
`endif
  logic              trc_valid;
  logic              trc_ready;
  logic [OVF_W-1:0]  ovf_count;
  logic              count_err;
  logic              test_has_ended;
  logic [$clog2(DEPTH):0] fill_level;

  int n_vec = 0;
  int n_err = 0;

  oci_trace_capture #(
    .SLOTS(SLOTS), .SLOT_W(SLOT_W), .DEPTH(DEPTH), .OVF_W(OVF_W), .TS_W(TS_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .trc_data(trc_data), .trc_valid(trc_valid),
    .trc_ready(trc_ready), .ovf_count(ovf_count), .count_err(count_err),
    .test_has_ended(test_has_ended), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards apply to the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [4+BW-1:0] ent(input logic [3:0] c, input logic [BW-1:0] b);
    return {c, b};
  endfunction

  initial begin
    dct_buffer = '0;
    dct_count = 4'd0;
    test_ending = 1'b0;
    trc_ready = 1'b0;
    reset_n = 1'b0;
    #2;
    // Reset state
    chk("rst_valid", 128'(trc_valid), 128'(0));
    chk("rst_data", 128'(trc_data), 128'(0));
    chk("rst_ovf", 128'(ovf_count), 128'(0));
    chk("rst_err", 128'(count_err), 128'(0));
    chk("rst_ended", 128'(test_has_ended), 128'(0));
    chk("rst_fill", 128'(fill_level), 128'(0));
    do_reset();

    // Single beat with ready held high
    trc_ready = 1'b1;
    dct_count = 4'd3;
    dct_buffer = 30'h0ABCDEF1;
    tick();
    dct_count = 4'd0;
    chk("single_valid", 128'(trc_valid), 128'(1));
    chk("single_data", 128'(trc_data[4+BW-1:0]), 128'(ent(4'd3, 30'h0ABCDEF1)));
    chk("single_fill1", 128'(fill_level), 128'(1));
    tick();
    chk("single_fill0", 128'(fill_level), 128'(0));
    chk("single_valid0", 128'(trc_valid), 128'(0));

    // Overflow: 20 beats into a 16-deep FIFO with no consumer
    trc_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dct_count = 4'd1;
      dct_buffer = BW'(i + 1);
      tick();
    end
    dct_count = 4'd0;
    chk("ovf_fill", 128'(fill_level), 128'(16));
    chk("ovf_count", 128'(ovf_count), 128'(4));

    // Full FIFO, simultaneous pop and beat: beat accepted
    trc_ready = 1'b1;
    dct_count = 4'd1;
    dct_buffer = BW'(32'h63);
    chk("ovf_head", 128'(trc_data[4+BW-1:0]), 128'(ent(4'd1, BW'(1))));
    tick();
    dct_count = 4'd0;
    chk("fullpop_fill", 128'(fill_level), 128'(16));
    chk("fullpop_ovf", 128'(ovf_count), 128'(4));
    for (int k = 0; k < 15; k++) begin
      chk("ovf_order", 128'(trc_data[4+BW-1:0]), 128'(ent(4'd1, BW'(k + 2))));
      tick();
    end
    chk("fullpop_last", 128'(trc_data[4+BW-1:0]), 128'(ent(4'd1, BW'(32'h63))));
    tick();
    chk("ovf_empty_fill", 128'(fill_level), 128'(0));
    chk("ovf_empty_valid", 128'(trc_valid), 128'(0));

    // Clamped count
    trc_ready = 1'b0;
    dct_count = 4'd9;
    dct_buffer = 30'h12345678;
    tick();
    dct_count = 4'd0;
    chk("clamp_err", 128'(count_err), 128'(1));
    chk("clamp_data", 128'(trc_data[4+BW-1:0]), 128'(ent(4'd5, 30'h12345678)));
    trc_ready = 1'b1;
    tick();
    chk("clamp_err_sticky", 128'(count_err), 128'(1));
    chk("clamp_fill", 128'(fill_level), 128'(0));

    // Reset clears sticky status
    do_reset();
    chk("rst2_err", 128'(count_err), 128'(0));
    chk("rst2_ovf", 128'(ovf_count), 128'(0));

    // End-of-test drain
    trc_ready = 1'b0;
    dct_count = 4'd2;
    dct_buffer = BW'(32'h111); tick();
    dct_buffer = BW'(32'h222); tick();
    dct_buffer = BW'(32'h333); tick();
    dct_count = 4'd0;
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    chk("drain_ended0", 128'(test_has_ended), 128'(0));
    chk("drain_fill3", 128'(fill_level), 128'(3));
    dct_count = 4'd2;
    dct_buffer = BW'(32'h444); tick();
    dct_buffer = BW'(32'h555); tick();
    dct_count = 4'd0;
    chk("drain_ignore_fill", 128'(fill_level), 128'(3));
    chk("drain_ignore_ovf", 128'(ovf_count), 128'(0));
    trc_ready = 1'b1;
    chk("drain_pop1", 128'(trc_data[4+BW-1:0]), 128'(ent(4'd2, BW'(32'h111))));
    tick();
    chk("drain_pop2", 128'(trc_data[4+BW-1:0]), 128'(ent(4'd2, BW'(32'h222))));
    tick();
    chk("drain_pop3", 128'(trc_data[4+BW-1:0]), 128'(ent(4'd2, BW'(32'h333))));
    chk("drain_ended_pre", 128'(test_has_ended), 128'(0));
    tick();
    chk("drain_ended1", 128'(test_has_ended), 128'(1));
    chk("drain_valid0", 128'(trc_valid), 128'(0));
    chk("drain_ovf0", 128'(ovf_count), 128'(0));
    dct_count = 4'd1;
    test_ending = 1'b1;
    tick();
    dct_count = 4'd0;
    test_ending = 1'b0;
    chk("ended_ignore_fill", 128'(fill_level), 128'(0));
    chk("ended_sticky", 128'(test_has_ended), 128'(1));

    // Reset from ENDED clears test_has_ended without a clock edge
    reset_n = 1'b0;
    #1;
    chk("rst_async_ended", 128'(test_has_ended), 128'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Pulse on empty FIFO: DRAIN for one cycle, then ENDED
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    chk("pulse_n1", 128'(test_has_ended), 128'(0));
    tick();
    chk("pulse_n2", 128'(test_has_ended), 128'(1));

    // test_ending with a beat in the same cycle: beat captured
    do_reset();
    trc_ready = 1'b0;
    dct_count = 4'd4;
    dct_buffer = BW'(32'h7);
    test_ending = 1'b1;
    tick();
    dct_count = 4'd0;
    test_ending = 1'b0;
    chk("te_beat_fill", 128'(fill_level), 128'(1));
    tick();
    chk("te_beat_wait", 128'(test_has_ended), 128'(0));
    chk("te_beat_data", 128'(trc_data[4+BW-1:0]), 128'(ent(4'd4, BW'(32'h7))));
    // Reset mid-drain drops contents immediately
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 128'(trc_valid), 128'(0));
    chk("rst_mid_fill", 128'(fill_level), 128'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

`ifdef OCI_TRACE_TIMESTAMP_EN
    // Timestamps: beats at cycles 10 and 13 after reset release
    trc_ready = 1'b0;
    repeat (10) tick();
    dct_count = 4'd1;
    dct_buffer = BW'(32'hA);
    tick();
    dct_count = 4'd0;
    tick();
    tick();
    dct_count = 4'd1;
    dct_buffer = BW'(32'hD);
    tick();
    dct_count = 4'd0;
    chk("ts_first", 128'(trc_data), 128'({32'd10, ent(4'd1, BW'(32'hA))}));
    trc_ready = 1'b1;
    tick();
    chk("ts_second", 128'(trc_data), 128'({32'd13, ent(4'd1, BW'(32'hD))}));
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
